soft_decoder_scheduler: RTL
===========================

Name: soft_decoder_scheduler

Overview:
Round-robin front end that shares one soft_decoder instance among NUM_REQ strand requesters. It arbitrates, validates strand length, pulses the decoder start and holds strand/N stable, then waits for done with a timeout. Each job returns one tagged response over a valid/ready channel. Sits between the read-channel strand producers and the soft decoder.

Parameters:
DATA_WIDTH, 32, max post-IDS strand length in bits; width of strand bus
n, 10, pre-IDS codeword length; number of likelihood words
NUM_REQ, 4, number of requesters (>=2)
MIN_LEN, 8, smallest legal N
MAX_LEN, 32, largest legal N (<= DATA_WIDTH)
TIMEOUT_CYCLES, 4096, max cycles in WAIT before abort

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  NUM_REQ  per-requester job valid
req_ready  out  NUM_REQ  one-hot accept pulse
req_strand  in  NUM_REQ x DATA_WIDTH  strand r per requester
req_len  in  NUM_REQ x 32  N per requester (int)
dec_start  out  1  decoder start pulse
dec_N  out  32  N to decoder
dec_strand  out  DATA_WIDTH  strand to decoder
dec_done  in  1  decoder done (level; may stay high from previous job)
dec_likelyhood  in  n x 32 signed  decoder output, index 1..n
resp_valid  out  1  response valid
resp_ready  in  1  response consumer ready
resp_id  out  $clog2(NUM_REQ)  requester index
resp_status  out  2  00 OK, 01 BAD_LEN, 10 TIMEOUT
resp_likelyhood  out  n x 32 signed  captured likelihoods (zero unless OK)
busy  out  1  high in any state except IDLE

Behaviour:
- Reset: state IDLE; req_ready=0, dec_start=0, dec_N=0, dec_strand=0, resp_valid=0, resp_id=0, resp_status=0, resp_likelyhood all 0, rr pointer=0, timeout counter=0. rst mid-job aborts to IDLE with no response; decoder left to finish unobserved.
- States: IDLE, LAUNCH, WAIT, RESP.
- IDLE: if any req_valid, grant the first valid index at or after rr pointer (wrapping). req_ready[g]=1 for exactly that cycle (combinational on registered state and req_valid). Latch strand, len, id. rr pointer <= g+1 mod NUM_REQ.
- Length check uses latched len: MIN_LEN<=len<=MAX_LEN gives LAUNCH next; otherwise RESP with status BAD_LEN. No dec_start is issued on BAD_LEN.
- LAUNCH: one cycle, dec_start=1. dec_N/dec_strand are driven from the latched values from this cycle until leaving RESP. Clear armed flag and counter; next state WAIT.
- WAIT: counter increments each cycle. armed<=1 once dec_done is sampled 0, which rejects stale done from the prior job.
  - armed && dec_done: capture dec_likelyhood into resp_likelyhood, status OK, go to RESP.
  - Counter reaching TIMEOUT_CYCLES-1 without completion: status TIMEOUT, likelihood zeroed, go to RESP.
  - Completion and timeout in the same cycle: completion wins.
- RESP: resp_valid=1, all resp_* stable until resp_ready. On the valid&&ready cycle, resp_valid drops next cycle and the state returns to IDLE. No new grant is made in the cycle resp completes. Earliest next grant is the following cycle.
- Latency with an immediate decoder (done low in LAUNCH, high one cycle after): grant t, dec_start t+1, done seen t+3, resp_valid t+4.
- req_valid deassertion by non-granted requesters has no effect. Requesters must hold strand/len while valid.
- Width rules: counter is $clog2(TIMEOUT_CYCLES)+1 bits. req_len is compared as a signed int, so negative values are BAD_LEN.

Decomposition:
- Package soft_decoder_pkg holds:
  - status enum (ST_OK, ST_BAD_LEN, ST_TIMEOUT)
  - state enum
  - LIKELY_W=32 constant
  - likelihood array typedef shared with soft_decoder
- One sub-module, rr_arbiter (NUM_REQ): inputs req vector, pointer, enable; outputs one-hot grant and index.

Test Plan:
- Single job: req 2, len 16, strand 0x0000_A5C3, decoder model done after 20 cycles with likelyhood[k]=k*100. Required: one dec_start pulse, dec_N=16, then resp id=2, status OK, likelyhood[5]=500.
- Round-robin fairness: all 4 requesters valid continuously. Required: grants follow 0,1,2,3,0, with req_ready one-hot every grant.
- Bad length: len=40, then len=-1. Required: BAD_LEN responses, dec_start never asserted, likelyhood zero.
- Stale done and timeout: dec_done held at 1 throughout with TIMEOUT_CYCLES=64. Required: no premature OK, and resp status TIMEOUT exactly 64 WAIT cycles after LAUNCH.
- Backpressure: resp_ready low for 10 cycles after resp_valid. Required: resp fields stable, no new req_ready, and a grant on the cycle after the handshake.
- Reset mid-WAIT: assert rst for 1 cycle at WAIT cycle 5. Required: all outputs at reset values next cycle, and no response is emitted for the aborted job.

Source files
------------

// File: rtl/soft_decoder_pkg.sv
// Shared types and constants for the soft decoder scheduler and the soft decoder itself.
package soft_decoder_pkg;

  localparam int LIKELY_W = 32;
  localparam int LIKELY_N = 10;

  typedef enum logic [1:0] {
    ST_OK      = 2'b00,
    ST_BAD_LEN = 2'b01,
    ST_TIMEOUT = 2'b10
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_RESP
  } state_e;

  typedef logic signed [LIKELY_W-1:0] likely_arr_t [1:LIKELY_N];

  // Strand length is carried as a signed int, so negative lengths fall out as illegal.
  function automatic logic len_ok(input logic signed [31:0] len, input int lo, input int hi);
    return (len >= lo) && (len <= hi);
  endfunction

endpackage

// File: rtl/soft_decoder_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, wrapping.
module rr_arbiter
  import soft_decoder_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  input  logic                       en,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] idx,
  output logic                       vld
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    vld  = 1'b0;
    cand = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
      if (en && !vld && req[cand]) begin
        vld = 1'b1;
        idx = cand;
      end
    end
    if (vld) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/soft_decoder_scheduler.sv
// Shares one soft decoder among NUM_REQ strand requesters: arbitrate, length-check,
// launch, wait for done (with timeout), and return one tagged response per job.
module soft_decoder_scheduler
  import soft_decoder_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int n              = 10,
  parameter int NUM_REQ        = 4,
  parameter int MIN_LEN        = 8,
  parameter int MAX_LEN        = 32,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [DATA_WIDTH-1:0]        req_strand [NUM_REQ],
  input  logic signed [31:0]           req_len [NUM_REQ],
  output logic                         dec_start,
  output logic [31:0]                  dec_N,
  output logic [DATA_WIDTH-1:0]        dec_strand,
  input  logic                         dec_done,
  input  logic signed [LIKELY_W-1:0]   dec_likelyhood [1:n],
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [$clog2(NUM_REQ)-1:0]   resp_id,
  output logic [1:0]                   resp_status,
  output logic signed [LIKELY_W-1:0]   resp_likelyhood [1:n],
  output logic                         busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  state_e                      state_q, state_d;
  logic [IDX_W-1:0]            rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        armed_q, armed_d;
  logic [IDX_W-1:0]            resp_id_q, resp_id_d;
  status_e                     resp_status_q, resp_status_d;
  logic signed [LIKELY_W-1:0]  resp_lk_q [1:n];
  logic signed [LIKELY_W-1:0]  resp_lk_d [1:n];
  logic [31:0]                 dec_n_q, dec_n_d;
  logic [DATA_WIDTH-1:0]       dec_strand_q, dec_strand_d;

  logic [NUM_REQ-1:0]          gnt;
  logic [IDX_W-1:0]            gnt_idx;
  logic                        gnt_vld;
  logic signed [31:0]          len_sel;
  logic [DATA_WIDTH-1:0]       strand_sel;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .en  (state_q == S_IDLE),
    .gnt (gnt),
    .idx (gnt_idx),
    .vld (gnt_vld)
  );

  assign len_sel    = req_len[gnt_idx];
  assign strand_sel = req_strand[gnt_idx];

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    cnt_d         = cnt_q;
    armed_d       = armed_q;
    resp_id_d     = resp_id_q;
    resp_status_d = resp_status_q;
    resp_lk_d     = resp_lk_q;
    dec_n_d       = dec_n_q;
    dec_strand_d  = dec_strand_q;
    unique case (state_q)
      S_IDLE: begin
        if (gnt_vld) begin
          rr_ptr_d  = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
          resp_id_d = gnt_idx;
          resp_lk_d = '{default: '0};
          if (len_ok(len_sel, MIN_LEN, MAX_LEN)) begin
            state_d       = S_LAUNCH;
            resp_status_d = ST_OK;
            dec_n_d       = $unsigned(len_sel);
            dec_strand_d  = strand_sel;
          end else begin
            state_d       = S_RESP;
            resp_status_d = ST_BAD_LEN;
          end
        end
      end
      S_LAUNCH: begin
        cnt_d   = '0;
        armed_d = 1'b0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // A done level left over from the previous job is ignored until done has been seen low.
        if (!dec_done) armed_d = 1'b1;
        if (armed_q && dec_done) begin
          resp_lk_d     = dec_likelyhood;
          resp_status_d = ST_OK;
          state_d       = S_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          resp_lk_d     = '{default: '0};
          resp_status_d = ST_TIMEOUT;
          state_d       = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d      = S_IDLE;
          dec_n_d      = '0;
          dec_strand_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      rr_ptr_q      <= '0;
      cnt_q         <= '0;
      armed_q       <= 1'b0;
      resp_id_q     <= '0;
      resp_status_q <= ST_OK;
      resp_lk_q     <= '{default: '0};
      dec_n_q       <= '0;
      dec_strand_q  <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      cnt_q         <= cnt_d;
      armed_q       <= armed_d;
      resp_id_q     <= resp_id_d;
      resp_status_q <= resp_status_d;
      resp_lk_q     <= resp_lk_d;
      dec_n_q       <= dec_n_d;
      dec_strand_q  <= dec_strand_d;
    end
  end

  assign req_ready       = gnt;
  assign dec_start       = (state_q == S_LAUNCH);
  assign dec_N           = dec_n_q;
  assign dec_strand      = dec_strand_q;
  assign resp_valid      = (state_q == S_RESP);
  assign resp_id         = resp_id_q;
  assign resp_status     = resp_status_q;
  assign resp_likelyhood = resp_lk_q;
  assign busy            = (state_q != S_IDLE);

endmodule
